// File: rtl/adc_frame_pkg.sv
// adc_frame_pkg
// Shared types and helpers for the ADC frame sequencer:
//   state_t   - controller state encoding (IDLE, CAPTURE, DRAIN)
//   clog2     - constant-evaluable ceiling log2 for pointer widths
//   TSTRB_ALL - all-ones byte-strobe source, sliced to DATA_W/8 by users
package adc_frame_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DRAIN   = 2'd2
   } state_t;

   // Wide enough for any tdata width up to 1024 bits
   localparam logic [127:0] TSTRB_ALL = '1;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/adc_frame_ctrl_fifo.sv
// sync_fifo_fwft
// First-word-fall-through synchronous FIFO. The head entry is always
// presented on dout; a push while full is accepted when a pop happens in
// the same cycle.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset (empties the FIFO)
//   push, din   - write request and data (ignored when full without pop)
//   pop         - read request (ignored when empty)
//   dout        - head entry
//   full, empty - occupancy flags
//   count       - number of stored entries
module sync_fifo_fwft
   import adc_frame_pkg::*;
#(
   parameter int WIDTH = 33,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [clog2(DEPTH):0]  count
);

   localparam int AW = clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             wr_en_s;
   logic             rd_en_s;

   assign full    = (count_r == DEPTH_C);
   assign empty   = (count_r == '0);
   assign count   = count_r;
   assign dout    = mem_r[rd_ptr_r];
   assign rd_en_s = pop & ~empty;
   // A full FIFO still takes a write when the head leaves in the same cycle
   assign wr_en_s = push & (~full | rd_en_s);

   // Storage, pointers and occupancy; storage is cleared so dout reads 0 after reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         if (wr_en_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (rd_en_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({wr_en_s, rd_en_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/adc_frame_ctrl.sv
// adc_frame_ctrl
// Frame sequencer between the ADC sample stream and an AXI4-Stream master.
// Captures cfg_num_frames frames of cfg_frame_len samples (0 frames =
// continuous until cfg_stop), buffers them in a FWFT FIFO because the ADC
// cannot be stalled, marks frame ends with tlast and reports drops/progress.
// Ports:
//   m_axis_aclk, m_axis_aresetn   - clock, synchronous active-low reset
//   cfg_start, cfg_stop           - capture start / stop-at-boundary pulses
//   cfg_frame_len, cfg_num_frames - frame length (0 -> 1), frame count (0 -> continuous)
//   s_sample_valid, s_sample_data - ADC sample strobe and data (no ready)
//   m_axis_*                      - AXI4-Stream master (tstrb constant all-ones)
//   sts_*                         - busy, sticky overflow, drop count, delivered frames, done pulse
module adc_frame_ctrl
   import adc_frame_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int LEN_W      = 16,
   parameter int CNT_W      = 16
) (
   input  logic                m_axis_aclk,
   input  logic                m_axis_aresetn,
   input  logic                cfg_start,
   input  logic                cfg_stop,
   input  logic [LEN_W-1:0]    cfg_frame_len,
   input  logic [CNT_W-1:0]    cfg_num_frames,
   input  logic                s_sample_valid,
   input  logic [DATA_W-1:0]   s_sample_data,
   output logic [DATA_W-1:0]   m_axis_tdata,
   output logic [DATA_W/8-1:0] m_axis_tstrb,
   output logic                m_axis_tvalid,
   input  logic                m_axis_tready,
   output logic                m_axis_tlast,
   output logic                sts_busy,
   output logic                sts_overflow,
   output logic [CNT_W-1:0]    sts_drop_cnt,
   output logic [CNT_W-1:0]    sts_frames_done,
   output logic                sts_done
);

   state_t                     state_r;
   logic [LEN_W-1:0]           frame_len_r;
   logic [CNT_W-1:0]           num_frames_r;
   logic [LEN_W-1:0]           sample_idx_r;
   logic [CNT_W-1:0]           frame_wr_r;
   logic                       stop_pending_r;
   logic                       busy_r;
   logic                       overflow_r;
   logic [CNT_W-1:0]           drop_cnt_r;
   logic [CNT_W-1:0]           frames_done_r;
   logic                       done_r;

   logic [DATA_W:0]            fifo_dout_s;
   logic                       fifo_full_s;
   logic                       fifo_empty_s;
   logic [clog2(FIFO_DEPTH):0] fifo_count_s;
   logic                       pop_s;
   logic                       stop_now_s;
   logic                       push_req_s;
   logic                       accept_s;
   logic                       drop_s;
   logic                       tag_s;
   logic                       last_frame_s;

   assign pop_s        = ~fifo_empty_s & m_axis_tready;
   // Stop requested and no partial frame open: leave CAPTURE without taking the sample
   assign stop_now_s   = stop_pending_r & (sample_idx_r == '0);
   assign push_req_s   = (state_r == CAPTURE) & s_sample_valid & ~stop_now_s;
   assign accept_s     = push_req_s & (~fifo_full_s | pop_s);
   assign drop_s       = push_req_s & ~accept_s;
   assign tag_s        = (sample_idx_r == (frame_len_r - LEN_W'(1)));
   assign last_frame_s = (num_frames_r != '0) & ((frame_wr_r + CNT_W'(1)) == num_frames_r);

   sync_fifo_fwft #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (m_axis_aclk),
      .rst_n (m_axis_aresetn),
      .push  (accept_s),
      .pop   (pop_s),
      .din   ({tag_s, s_sample_data}),
      .dout  (fifo_dout_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .count (fifo_count_s)
   );

   assign m_axis_tdata    = fifo_dout_s[DATA_W-1:0];
   assign m_axis_tlast    = fifo_dout_s[DATA_W];
   assign m_axis_tvalid   = ~fifo_empty_s;
   assign m_axis_tstrb    = TSTRB_ALL[DATA_W/8-1:0];
   assign sts_busy        = busy_r;
   assign sts_overflow    = overflow_r;
   assign sts_drop_cnt    = drop_cnt_r;
   assign sts_frames_done = frames_done_r;
   assign sts_done        = done_r;

   // Capture state machine, frame bookkeeping and status counters
   always_ff @(posedge m_axis_aclk) begin
      if (!m_axis_aresetn) begin
         state_r        <= IDLE;
         frame_len_r    <= LEN_W'(1);
         num_frames_r   <= '0;
         sample_idx_r   <= '0;
         frame_wr_r     <= '0;
         stop_pending_r <= 1'b0;
         busy_r         <= 1'b0;
         overflow_r     <= 1'b0;
         drop_cnt_r     <= '0;
         frames_done_r  <= '0;
         done_r         <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (pop_s & fifo_dout_s[DATA_W]) begin
            frames_done_r <= frames_done_r + CNT_W'(1);
         end
         case (state_r)
            IDLE: begin
               if (cfg_start) begin
                  frame_len_r    <= (cfg_frame_len == '0) ? LEN_W'(1) : cfg_frame_len;
                  num_frames_r   <= cfg_num_frames;
                  sample_idx_r   <= '0;
                  frame_wr_r     <= '0;
                  stop_pending_r <= 1'b0;
                  overflow_r     <= 1'b0;
                  drop_cnt_r     <= '0;
                  frames_done_r  <= '0;
                  busy_r         <= 1'b1;
                  state_r        <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (cfg_stop) begin
                  stop_pending_r <= 1'b1;
               end
               if (drop_s) begin
                  overflow_r <= 1'b1;
                  if (drop_cnt_r != '1) begin
                     drop_cnt_r <= drop_cnt_r + CNT_W'(1);
                  end
               end
               if (stop_now_s) begin
                  state_r <= DRAIN;
               end else if (accept_s) begin
                  if (tag_s) begin
                     sample_idx_r <= '0;
                     frame_wr_r   <= frame_wr_r + CNT_W'(1);
                     if (last_frame_s | stop_pending_r) begin
                        state_r <= DRAIN;
                     end
                  end else begin
                     sample_idx_r <= sample_idx_r + LEN_W'(1);
                  end
               end
            end
            DRAIN: begin
               if (fifo_count_s == '0) begin
                  state_r        <= IDLE;
                  busy_r         <= 1'b0;
                  done_r         <= 1'b1;
                  stop_pending_r <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_frame_ctrl.sv
module tb_adc_frame_ctrl;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 16;
   localparam int LEN_W  = 16;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              rstn, start, stop, sv, tready;
   logic [LEN_W-1:0]  flen;
   logic [CNT_W-1:0]  nfr;
   logic [DATA_W-1:0] sd;
   logic [DATA_W-1:0] tdata;
   logic [3:0]        tstrb;
   logic              tvalid, tlast, busy, ovf, done;
   logic [CNT_W-1:0]  drops, fdone;

   always #5 clk = ~clk;

   adc_frame_ctrl #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
      .m_axis_aclk     (clk),
      .m_axis_aresetn  (rstn),
      .cfg_start       (start),
      .cfg_stop        (stop),
      .cfg_frame_len   (flen),
      .cfg_num_frames  (nfr),
      .s_sample_valid  (sv),
      .s_sample_data   (sd),
      .m_axis_tdata    (tdata),
      .m_axis_tstrb    (tstrb),
      .m_axis_tvalid   (tvalid),
      .m_axis_tready   (tready),
      .m_axis_tlast    (tlast),
      .sts_busy        (busy),
      .sts_overflow    (ovf),
      .sts_drop_cnt    (drops),
      .sts_frames_done (fdone),
      .sts_done        (done)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   logic [32:0] mq[$];          // beats expected downstream, in order {tlast, data}
   bit m_ok = 0;
   bit m_busy, m_drain, m_stop, m_ovf, m_done;
   int m_idx, m_fw, m_fl, m_nf, m_drops, m_fdone;

   always @(posedge clk) begin : model
      bit pop_b;
      bit tag_b;
      int sz;
      if (!rstn) begin
         mq.delete();
         m_busy = 0; m_drain = 0; m_stop = 0; m_ovf = 0; m_done = 0;
         m_idx = 0; m_fw = 0; m_fl = 1; m_nf = 0; m_drops = 0; m_fdone = 0;
         m_ok = 1;
      end else begin
         sz    = mq.size();
         pop_b = (sz != 0) && tready;
         m_done = 0;
         if (!m_busy) begin
            if (start) begin
               m_fl = (flen == 0) ? 1 : int'(flen);
               m_nf = int'(nfr);
               m_idx = 0; m_fw = 0; m_stop = 0; m_ovf = 0; m_drops = 0; m_fdone = 0;
               m_busy = 1; m_drain = 0;
            end
         end else if (!m_drain) begin
            if (m_stop && m_idx == 0) begin
               m_drain = 1;
            end else if (sv) begin
               if (sz < DEPTH || pop_b) begin
                  tag_b = (m_idx == m_fl - 1);
                  mq.push_back({tag_b, sd});
                  if (tag_b) begin
                     m_idx = 0;
                     m_fw++;
                     if ((m_nf != 0 && m_fw == m_nf) || m_stop) m_drain = 1;
                  end else begin
                     m_idx++;
                  end
               end else begin
                  m_ovf = 1;
                  if (m_drops < 65535) m_drops++;
               end
            end
            if (stop) m_stop = 1;
         end else if (sz == 0) begin
            m_busy = 0; m_drain = 0; m_done = 1; m_stop = 0;
         end
         if (pop_b) begin
            if (mq[0][32]) m_fdone = (m_fdone + 1) % 65536;
            void'(mq.pop_front());
         end
      end
   end

   // ---------------- per-cycle compare + handshake log ----------------
   logic [32:0] log_q[$];
   int done_seen;

   always @(negedge clk) begin
      if (m_ok) begin
         check("tvalid", {63'd0, tvalid}, {63'd0, (mq.size() != 0)});
         if (mq.size() != 0) begin
            check("tdata", {32'd0, tdata}, {32'd0, mq[0][31:0]});
            check("tlast", {63'd0, tlast}, {63'd0, mq[0][32]});
         end
         check("tstrb", {60'd0, tstrb}, 64'hF);
         check("busy", {63'd0, busy}, {63'd0, m_busy});
         check("overflow", {63'd0, ovf}, {63'd0, m_ovf});
         check("drop_cnt", {48'd0, drops}, 64'(m_drops));
         check("frames_done", {48'd0, fdone}, 64'(m_fdone));
         check("done", {63'd0, done}, {63'd0, m_done});
         if (tvalid && tready) log_q.push_back({tlast, tdata});
         if (done) done_seen++;
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [31:0] dval = 0;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic sample_cycle(input bit v);
      sv = v;
      if (v) begin
         dval = dval + 32'd1;
         sd = dval;
      end
      cyc();
      sv = 1'b0;
   endtask

   task automatic pulse_start(input int fl, input int nf);
      flen = LEN_W'(fl);
      nfr = CNT_W'(nf);
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input bit feed);
      bit reached;
      reached = 0;
      tready = 1'b1;
      start = 1'b0;
      stop = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (!busy && !tvalid) begin
            reached = 1;
            break;
         end
         sample_cycle(feed);
      end
      cyc();
      check("idle_reached", {63'd0, reached}, 64'd1);
   endtask

   task automatic check_beat(input string name, input int i, input logic [32:0] exp);
      if (i < log_q.size()) check(name, {31'd0, log_q[i]}, {31'd0, exp});
      else check({name, "_missing"}, 64'(log_q.size()), 64'(i + 1));
   endtask

   logic [31:0] base;

   initial begin
      rstn = 0; start = 0; stop = 0; sv = 0; tready = 0; flen = 0; nfr = 0; sd = 0;
      done_seen = 0;
      cyc(); cyc();
      rstn = 1;
      // reset state, hand-computed
      check("rst_tvalid", {63'd0, tvalid}, 64'd0);
      check("rst_tdata", {32'd0, tdata}, 64'd0);
      check("rst_tlast", {63'd0, tlast}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);

      // 1: len 4, 2 frames, samples every cycle
      log_q.delete(); done_seen = 0; tready = 1; base = dval;
      pulse_start(4, 2);
      for (int i = 0; i < 10; i++) sample_cycle(1);
      wait_idle(100, 0);
      check("t1_beats", 64'(log_q.size()), 64'd8);
      for (int i = 0; i < 8; i++) check_beat("t1_beat", i, {1'(i % 4 == 3), base + 32'(i + 1)});
      check("t1_frames", {48'd0, fdone}, 64'd2);
      check("t1_done", 64'(done_seen), 64'd1);
      check("t1_drops", {48'd0, drops}, 64'd0);

      // 2: overflow with tready low, len 64, 1 frame
      log_q.delete(); tready = 0; base = dval;
      pulse_start(64, 1);
      for (int i = 0; i < 20; i++) sample_cycle(1);
      cyc();
      check("t2_drops", {48'd0, drops}, 64'd4);
      check("t2_ovf", {63'd0, ovf}, 64'd1);
      check("t2_nobeats", 64'(log_q.size()), 64'd0);
      tready = 1;
      for (int i = 0; i < 20; i++) cyc();
      check("t2_beats16", 64'(log_q.size()), 64'd16);
      for (int i = 0; i < 16; i++) check_beat("t2_beat", i, {1'b0, base + 32'(i + 1)});
      for (int i = 0; i < 48; i++) sample_cycle(1);
      wait_idle(100, 0);
      check("t2_beats64", 64'(log_q.size()), 64'd64);
      check_beat("t2_last", 63, {1'b1, base + 32'd68});
      check("t2_frames", {48'd0, fdone}, 64'd1);

      // 3: continuous, stop after sample 3
      log_q.delete(); tready = 1; base = dval;
      pulse_start(8, 0);
      for (int i = 0; i < 3; i++) sample_cycle(1);
      stop = 1;
      sample_cycle(1);
      stop = 0;
      for (int i = 0; i < 10; i++) sample_cycle(1);
      wait_idle(100, 0);
      check("t3_beats", 64'(log_q.size()), 64'd8);
      for (int i = 0; i < 8; i++) check_beat("t3_beat", i, {1'(i == 7), base + 32'(i + 1)});
      check("t3_frames", {48'd0, fdone}, 64'd1);

      // 4: random tready, 2 samples per 5 cycles, len 5, 3 frames
      log_q.delete(); base = dval;
      pulse_start(5, 3);
      for (int k = 0; k < 60; k++) begin
         tready = 1'($urandom_range(0, 1));
         sample_cycle(k % 5 == 0 || k % 5 == 2);
      end
      wait_idle(100, 0);
      check("t4_beats", 64'(log_q.size()), 64'd15);
      for (int i = 0; i < 15; i++) check_beat("t4_beat", i, {1'(i % 5 == 4), base + 32'(i + 1)});
      check("t4_drops", {48'd0, drops}, 64'd0);
      check("t4_frames", {48'd0, fdone}, 64'd3);

      // 5: reset mid-frame with 6 entries buffered
      tready = 0;
      pulse_start(10, 1);
      for (int i = 0; i < 6; i++) sample_cycle(1);
      rstn = 0;
      cyc();
      rstn = 1;
      check("t5_tvalid", {63'd0, tvalid}, 64'd0);
      check("t5_busy", {63'd0, busy}, 64'd0);
      log_q.delete(); tready = 1; base = dval;
      pulse_start(3, 1);
      for (int i = 0; i < 3; i++) sample_cycle(1);
      wait_idle(100, 0);
      check("t5_beats", 64'(log_q.size()), 64'd3);
      for (int i = 0; i < 3; i++) check_beat("t5_beat", i, {1'(i == 2), base + 32'(i + 1)});

      // 6: frame_len 0, restart attempt while capturing is ignored
      log_q.delete(); base = dval;
      pulse_start(0, 3);
      sample_cycle(1);
      flen = 16'd7; nfr = 16'd1; start = 1;
      sample_cycle(1);
      start = 0;
      for (int i = 0; i < 3; i++) sample_cycle(1);
      wait_idle(100, 0);
      check("t6_beats", 64'(log_q.size()), 64'd3);
      for (int i = 0; i < 3; i++) check_beat("t6_beat", i, {1'b1, base + 32'(i + 1)});
      check("t6_frames", {48'd0, fdone}, 64'd3);

      // random runs against the model
      for (int r = 0; r < 6; r++) begin
         pulse_start(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
         for (int k = 0; k < 120; k++) begin
            tready = ($urandom_range(0, 3) != 0);
            stop = ($urandom_range(0, 40) == 0);
            start = ($urandom_range(0, 30) == 0);
            flen = LEN_W'($urandom_range(0, 6));
            nfr = CNT_W'($urandom_range(0, 3));
            sample_cycle(1'($urandom_range(0, 1)));
         end
         start = 0;
         stop = 1;
         cyc();
         stop = 0;
         wait_idle(400, 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/adc_frame_ctrl.md
Name: adc_frame_ctrl

Overview:
Frame sequencer between the ADC sample path (after the CDC into the stream clock) and the AXI4-Stream master output. It captures a configured number of fixed-length frames on software command and buffers samples, because the ADC cannot be stalled. It inserts tlast at frame boundaries, absorbs tready backpressure in a small FIFO, and reports drops and progress. Single clock domain, m_axis_aclk (200 MHz).

Parameters:
DATA_W, 32, sample/tdata width (multiple of 8)
FIFO_DEPTH, 16, buffer entries; power of 2, >= 4
LEN_W, 16, width of frame length field
CNT_W, 16, width of frame count and drop counter

Ports:
m_axis_aclk  in  1  clock
m_axis_aresetn  in  1  reset; synchronous to m_axis_aclk, active-low
cfg_start  in  1  one-cycle pulse, begin capture
cfg_stop  in  1  one-cycle pulse, stop at next frame boundary
cfg_frame_len  in  LEN_W  samples per frame; 0 treated as 1
cfg_num_frames  in  CNT_W  frames to capture; 0 = continuous
s_sample_valid  in  1  sample strobe from ADC path (no ready)
s_sample_data  in  DATA_W  sample
m_axis_tdata  out  DATA_W  stream data
m_axis_tstrb  out  DATA_W/8  byte strobes
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tlast  out  1  last beat of frame
sts_busy  out  1  state != IDLE
sts_overflow  out  1  sticky: at least one sample dropped
sts_drop_cnt  out  CNT_W  dropped samples, saturating
sts_frames_done  out  CNT_W  frames fully delivered downstream
sts_done  out  1  one-cycle pulse on return to IDLE

Behaviour:
- Reset (m_axis_aresetn=0 at a clock edge): state IDLE, FIFO empty, all counters 0.
  - Outputs after reset: tvalid=0, tlast=0, tdata=0, busy=0, overflow=0, done=0.
  - tstrb is constant all-ones.
  - Reset mid-frame discards buffered data. No tlast is emitted for the partial frame.
- States: IDLE, CAPTURE, DRAIN.
- IDLE:
  - s_sample_valid is ignored.
  - On cfg_start: latch frame_len and num_frames; clear overflow, drop_cnt and frames_done; go to CAPTURE.
  - If cfg_start and cfg_stop are both asserted, start wins.
- CAPTURE:
  - Each s_sample_valid writes {tag, data} into the FIFO, where tag = (sample_idx == frame_len-1).
  - sample_idx counts accepted samples only. It wraps to 0 after a tagged write, and frame_wr increments.
  - A write is accepted if the FIFO is not full, or if a pop happens in the same cycle (tvalid & tready).
  - Otherwise the sample is dropped: overflow←1, and drop_cnt increments, saturating at all-ones.
  - Dropped samples do not advance sample_idx, so frame length is exact in accepted samples.
  - cfg_stop sets stop_pending. cfg_start is ignored while busy.
  - Go to DRAIN on either condition:
    - a tagged write when (num_frames != 0 and frame_wr+1 == num_frames) or stop_pending;
    - stop_pending with sample_idx == 0 (boundary already reached; stop takes effect next cycle).
- DRAIN:
  - Samples are ignored (not counted as drops).
  - When the FIFO is empty: go to IDLE, pulse sts_done for 1 cycle, clear stop_pending.
- FIFO and output behaviour:
  - The FIFO is first-word-fall-through; tvalid = !empty.
  - A sample written at edge n is visible on tdata/tlast after edge n (earliest beat completes at edge n+1).
  - tdata/tlast are stable while tvalid & !tready (AXIS rule). tvalid never drops without a handshake, except on reset.
- sts_frames_done increments on each handshake with tlast=1, and wraps at 2^CNT_W.
- frame_len = 1: every beat carries tlast.
- Continuous mode (num_frames = 0) runs until cfg_stop.

Decomposition:
- Package adc_frame_pkg:
  - state enum {IDLE, CAPTURE, DRAIN};
  - function clog2;
  - constant TSTRB_ALL.
- Sub-module sync_fifo_fwft (WIDTH = DATA_W+1, DEPTH = FIFO_DEPTH):
  - outputs full/empty/count;
  - simultaneous push+pop when full is legal.
- Controller, counters and status logic stay in adc_frame_ctrl.

Test Plan:
1. frame_len=4, num_frames=2, tready=1, samples every cycle, data 1..10 → beats 1..8, tlast on 4 and 8. Samples 9 and 10 ignored. frames_done=2, done pulse, drop_cnt=0.
2. FIFO_DEPTH=16, frame_len=64, num_frames=1, tready=0 throughout capture of 20 samples → 16 buffered, drop_cnt=4, overflow=1. Raise tready: 16 beats, data unchanged while stalled, no tlast yet.
3. Continuous mode, frame_len=8; assert cfg_stop after accepted sample 3 → capture continues to sample 8, single tlast on beat 8, then DRAIN→IDLE. frames_done=1.
4. Random tready (50%), samples every 2.5 cycles, frame_len=5, num_frames=3 → 15 beats, correct order, tlast on beats 5/10/15. No tdata change while tvalid & !tready. drop_cnt=0.
5. Deassert m_axis_aresetn for 1 cycle mid-frame with 6 entries buffered → next cycle tvalid=0, busy=0. Subsequent cfg_start captures cleanly from sample_idx 0.
6. cfg_start pulsed while in CAPTURE, and frame_len=0 → restart ignored, latched config unchanged. A frame_len=0 run emits tlast on every beat.
